// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB stage bus bundle
//   stall, flush      : pipeline control from the hazard unit
//   mem_*             : instruction fields leaving the MEM stage
//   writeReg/Data     : register-file write port and decode-stage bypass
//   RegWrite          : register-file write enable
//   wb_valid          : WB stage holds a real instruction
//   retire_count      : retired-instruction counter
//   master drives mem_* and control, slave is the WB stage
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic             mem_valid;
  logic             mem_RegWrite;
  logic [1:0]       mem_WBSel;
  logic [2:0]       mem_LoadType;
  logic [31:0]      mem_ALUResult;
  logic [31:0]      mem_ReadData;
  logic [31:0]      mem_PC;
  logic [4:0]       mem_WriteReg;
  logic [4:0]       writeReg;
  logic [31:0]      writeData;
  logic             RegWrite;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output stall, flush, mem_valid, mem_RegWrite, mem_WBSel, mem_LoadType,
           mem_ALUResult, mem_ReadData, mem_PC, mem_WriteReg,
    input  writeReg, writeData, RegWrite, wb_valid, retire_count
  );

  modport slave (
    input  stall, flush, mem_valid, mem_RegWrite, mem_WBSel, mem_LoadType,
           mem_ALUResult, mem_ReadData, mem_PC, mem_WriteReg,
    output writeReg, writeData, RegWrite, wb_valid, retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, write-back select and load alignment
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low
//   bus  : wb_stage_if slave (control and mem_* in, register-file write triple,
//          wb_valid and retire_count out)
module wb_stage #(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter int          CNT_W       = 32
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave bus
);

  logic             valid_q;
  logic             regwrite_q;
  logic [1:0]       wbsel_q;
  logic [2:0]       loadtype_q;
  logic [31:0]      alu_q;
  logic [31:0]      rdata_q;
  logic [31:0]      pc_q;
  logic [4:0]       wreg_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wbsel_q    <= 2'd0;
      loadtype_q <= 3'd0;
      alu_q      <= 32'd0;
      rdata_q    <= 32'd0;
      pc_q       <= 32'd0;
      wreg_q     <= 5'd0;
      count_q    <= '0;
    end else begin
      // Flush beats stall: a bubble is inserted even while the stage is held.
      if (bus.flush) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        wbsel_q    <= 2'd0;
        loadtype_q <= 3'd0;
        alu_q      <= 32'd0;
        rdata_q    <= 32'd0;
        pc_q       <= 32'd0;
        wreg_q     <= 5'd0;
      end else if (!bus.stall) begin
        valid_q    <= bus.mem_valid;
        regwrite_q <= bus.mem_RegWrite;
        wbsel_q    <= bus.mem_WBSel;
        loadtype_q <= bus.mem_LoadType;
        alu_q      <= bus.mem_ALUResult;
        rdata_q    <= bus.mem_ReadData;
        pc_q       <= bus.mem_PC;
        wreg_q     <= bus.mem_WriteReg;
      end
      // The instruction in WB retires when it is allowed to leave; a flush
      // only affects what enters, so it does not block counting.
      if (valid_q && !bus.stall) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Big-endian lane selection: offset 0 is the most significant byte.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  always_comb begin
    byte_sel = rdata_q[31:24];
    case (alu_q[1:0])
      2'd0: byte_sel = rdata_q[31:24];
      2'd1: byte_sel = rdata_q[23:16];
      2'd2: byte_sel = rdata_q[15:8];
      2'd3: byte_sel = rdata_q[7:0];
      default: byte_sel = rdata_q[31:24];
    endcase
  end

  // Half-word select ignores offset bit 0; misaligned halves are not trapped.
  assign half_sel = alu_q[1] ? rdata_q[15:0] : rdata_q[31:16];

  always_comb begin
    load_data = rdata_q;
    case (loadtype_q)
      3'd1: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2: load_data = {24'd0, byte_sel};
      3'd3: load_data = {{16{half_sel[15]}}, half_sel};
      3'd4: load_data = {16'd0, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    wb_data = alu_q;
    case (wbsel_q)
      2'd1: wb_data = load_data;
      2'd2: wb_data = pc_q + LINK_OFFSET;
      default: wb_data = alu_q;
    endcase
  end

  assign bus.writeReg     = wreg_q;
  assign bus.writeData    = wb_data;
  assign bus.RegWrite     = valid_q && regwrite_q && (wreg_q != 5'd0);
  assign bus.wb_valid     = valid_q;
  assign bus.retire_count = count_q;

endmodule
